// File: rtl/traffic_sequencer_pkg.sv
// Shared encodings for the traffic sequencer: store select codes, lamp patterns,
// phase/state enums and the duration clamp.
package traffic_sequencer_pkg;

  localparam logic [1:0] SEL_RED = 2'b00;
  localparam logic [1:0] SEL_YEL = 2'b01;
  localparam logic [1:0] SEL_GRN = 2'b11;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam logic [6:0] MAX_SEC = 7'd99;

  // Phase codes double as the store select codes.
  typedef enum logic [1:0] {
    PH_RED = SEL_RED,
    PH_YEL = SEL_YEL,
    PH_GRN = SEL_GRN
  } phase_e;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:  return PH_GRN;
      PH_GRN:  return PH_YEL;
      default: return PH_RED;
    endcase
  endfunction

  function automatic logic [2:0] phase_light(input phase_e p);
    case (p)
      PH_GRN:  return LIGHT_GRN;
      PH_YEL:  return LIGHT_YEL;
      default: return LIGHT_RED;
    endcase
  endfunction

  function automatic logic [6:0] clamp_sec(input logic [6:0] v);
    if (v == 7'd0)   return 7'd1;
    if (v > MAX_SEC) return MAX_SEC;
    return v;
  endfunction

endpackage

// File: rtl/traffic_sequencer_tick.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on wrap.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count_q, count_d;

  assign tick = en & ~clr & (count_q == LAST);

  always_comb begin
    count_d = count_q;
    if (clr)       count_d = '0;
    else if (tick) count_d = '0;
    else if (en)   count_d = count_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/traffic_sequencer.sv
// Traffic light sequencer: RED -> GREEN -> YELLOW, each phase loading its duration
// in seconds from an external store, then counting it down on prescaled ticks.
module traffic_sequencer
  import traffic_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       restart,
  output logic [1:0] tm_select,
  input  logic [6:0] tm_q,
  output logic [2:0] light,
  output logic [6:0] remain,
  output logic       phase_done
);

  state_e     state_q, state_d;
  phase_e     phase_q, phase_d;
  logic [6:0] remain_q, remain_d;
  logic       done_q, done_d;
  logic [1:0] sel_q, sel_d;
  logic       tick;
  logic       pre_clr;
  logic       pre_en;

  // The prescaler is held at zero through LOAD so every phase starts on a full second.
  assign pre_clr = restart | (state_q == ST_LOAD);
  assign pre_en  = en & (state_q == ST_RUN);

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    if (restart) begin
      state_d  = ST_LOAD;
      phase_d  = PH_RED;
      remain_d = 7'd0;
    end else if (state_q == ST_LOAD) begin
      remain_d = clamp_sec(tm_q);
      state_d  = ST_RUN;
    end else if (tick) begin
      if (remain_q > 7'd1) begin
        remain_d = remain_q - 7'd1;
      end else begin
        phase_d  = next_phase(phase_q);
        remain_d = 7'd0;
        done_d   = 1'b1;
        state_d  = ST_LOAD;
      end
    end
    // Tracks the next phase so the select is already valid during LOAD.
    sel_d = phase_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_LOAD;
      phase_q  <= PH_RED;
      remain_q <= 7'd0;
      done_q   <= 1'b0;
      sel_q    <= SEL_RED;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      remain_q <= remain_d;
      done_q   <= done_d;
      sel_q    <= sel_d;
    end
  end

  assign light      = phase_light(phase_q);
  assign tm_select  = sel_q;
  assign remain     = remain_q;
  assign phase_done = done_q;

endmodule
